// File: rtl/control_sequencer.sv
// control_sequencer
//
// Hardwired control unit for a simple bus-based CPU datapath. A registered
// step counter walks T0..T7; every control output is decoded
// combinationally from (step, IR opcode, CON). The fetch steps T0..T2 are
// common to all instructions, and the opcode takes effect from T3 onward.
//
// Optional feature (macro INSTR_COUNT_EN): when defined, InstrCount counts
// retired instructions and wraps at 2^32. When undefined, InstrCount is tied
// to zero and no counter register is built.
//
// Ports
//   Clock        in   system clock, rising edge
//   Clear        in   synchronous active-high reset
//   IR[31:0]     in   instruction register, opcode = IR[31:27]
//   CON          in   branch condition from the datapath
//   Stop         in   halt request, honoured only at T0
//   PCout, Zhiout, Zlowout, MDRout, Cout, BAout   out  bus-drive selects
//   PCin, MARin, MDRin, IRin, Yin, Zin, Rin       out  register load enables
//   Gra, Grb, Grc, Rout, IncPC, Read, Write, CONIn out register select / misc
//   ALUsel[3:0]  out  0000 ADD, 0001 SUB, 0010 AND, 0011 OR
//   Run          out  high while sequencing, low when halted
//   InstrCount   out  retired-instruction count
//
// State   | meaning
// --------+-----------------------------------------------------------
// T0      | fetch: PC -> MAR, PC+1 -> Z
// T1      | fetch: Z -> PC, memory read into MDR
// T2      | fetch: MDR -> IR; nop/halt/undefined retire here
// T3..T7  | execute steps, opcode dependent
// halted  | Run=0, all controls 0, step frozen until Clear

module control_sequencer (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zhiout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        BAout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Rin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rout,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        CONIn,
    output logic [3:0]  ALUsel,
    output logic        Run,
    output logic [31:0] InstrCount
);

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, T7} step_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_JAL  = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    step_t      step;
    logic       halted;
    logic       last_step;
    logic       active;
    logic [4:0] opcode;
    logic [3:0] alu_op;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];
    assign active    = !Clear && !halted;
    assign Run       = !halted;

    // Final step of each instruction; nop, halt and undefined opcodes end at T2.
    always_comb begin
        last_step = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: last_step = (step == T5);
            OP_LD, OP_ST:                           last_step = (step == T7);
            OP_JAL:                                 last_step = (step == T4);
            OP_JR:                                  last_step = (step == T3);
            OP_BR:                                  last_step = (step == T6);
            default:                                last_step = (step == T2);
        endcase
    end

    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            default: alu_op = ALU_ADD;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            step   <= T0;
            halted <= 1'b0;
        end else if (!halted) begin
            if (step == T0 && Stop) begin
                halted <= 1'b1;
            end else if (last_step) begin
                step <= T0;
                if (opcode == OP_HALT)
                    halted <= 1'b1;
            end else begin
                step <= step_t'(step + 3'd1);
            end
        end
    end

`ifdef INSTR_COUNT_EN
    logic [31:0] instr_count_q;
    logic        retire;

    // last_step is never true at T0, so a Stop at T0 cannot also retire.
    assign retire = active && last_step;

    always_ff @(posedge Clock) begin
        if (Clear)
            instr_count_q <= '0;
        else if (retire)
            instr_count_q <= instr_count_q + 32'd1;
    end

    assign InstrCount = instr_count_q;
`else
    assign InstrCount = '0;
`endif

    always_comb begin
        PCout   = 1'b0;
        Zhiout  = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        Cout    = 1'b0;
        BAout   = 1'b0;
        PCin    = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Rin     = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rout    = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        CONIn   = 1'b0;
        ALUsel  = ALU_ADD;

        if (active) begin
            case (step)
                T0: begin
                    // A pending Stop suppresses T0 so nothing is loaded on the halting edge.
                    if (!Stop) begin
                        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                    end
                end
                T1: begin
                    Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                end
                T2: begin
                    MDRout = 1'b1; IRin = 1'b1;
                end
                T3: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                        end
                        OP_LD, OP_ST: begin
                            Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                        end
                        OP_JAL: begin
                            PCout = 1'b1; Grb = 1'b1; Rin = 1'b1;
                        end
                        OP_JR: begin
                            Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                        end
                        OP_BR: begin
                            Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                            Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUsel = alu_op;
                        end
                        OP_ADDI, OP_LD, OP_ST: begin
                            Cout = 1'b1; Zin = 1'b1; ALUsel = ALU_ADD;
                        end
                        OP_JAL: begin
                            Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                        end
                        OP_BR: begin
                            PCout = 1'b1; Yin = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end
                        OP_LD, OP_ST: begin
                            Zlowout = 1'b1; MARin = 1'b1;
                        end
                        OP_BR: begin
                            Cout = 1'b1; Zin = 1'b1; ALUsel = ALU_ADD;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_LD: begin
                            Read = 1'b1; MDRin = 1'b1;
                        end
                        OP_ST: begin
                            Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                        end
                        OP_BR: begin
                            if (CON) begin
                                Zlowout = 1'b1; PCin = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                T7: begin
                    case (opcode)
                        OP_LD: begin
                            MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end
                        OP_ST: begin
                            Write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port Clock, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port Clear, input, 1, synchronous active-high reset.
REQ-003 SHALL have port IR, input, 32, instruction register contents; opcode = IR[31:27].
REQ-004 SHALL have port CON, input, 1, branch-condition flip-flop output from datapath.
REQ-005 SHALL have port Stop, input, 1, external halt request.
REQ-006 SHALL have ports PCout, Zhiout, Zlowout, MDRout, Cout, BAout, outputs, 1 each, bus-drive selects.
REQ-007 SHALL have ports PCin, MARin, MDRin, IRin, Yin, Zin, Rin, outputs, 1 each, register load enables.
REQ-008 SHALL have ports Gra, Grb, Grc, Rout, IncPC, Read, Write, CONIn, outputs, 1 each, register select and misc controls.
REQ-009 SHALL have port ALUsel, output, 4, ALU op: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR.
REQ-010 SHALL have port Run, output, 1, high while sequencing, low when halted.
REQ-011 SHALL have port InstrCount, output, 32, retired-instruction count.

Function
REQ-012 SHALL keep a registered step counter T0..T7; all controls SHALL be combinational from (step, IR opcode, CON), one step per clock.
REQ-013 Fetch SHALL be: T0 PCout MARin IncPC Zin; T1 Zlowout PCin Read MDRin; T2 MDRout IRin. Opcode is decoded from T3 onward.
REQ-014 Opcodes: ld 00000, st 00001, add 00011, sub 00100, and 00101, or 00110, addi 01100, jal 10011, jr 10100, br 10010, nop 11010, halt 11011.
REQ-015 add/sub/and/or SHALL be: T3 Grb Rout Yin; T4 Grc Rout Zin ALUsel=op; T5 Zlowout Gra Rin; then T0.
REQ-016 addi SHALL be: T3 Grb Rout Yin; T4 Cout Zin ALUsel=ADD; T5 Zlowout Gra Rin; then T0.
REQ-017 ld SHALL be: T3 Grb BAout Yin; T4 Cout Zin ADD; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin; then T0.
REQ-018 st SHALL be: T3-T5 as ld; T6 Gra Rout MDRin; T7 Write; then T0.
REQ-019 jal SHALL be: T3 PCout Grb Rin (link); T4 Gra Rout PCin; then T0.
REQ-020 jr SHALL be: T3 Gra Rout PCin; then T0.
REQ-021 br SHALL be: T3 Gra Rout CONIn; T4 PCout Yin; T5 Cout Zin ADD; T6 Zlowout PCin only if CON=1, otherwise no controls; then T0.
REQ-022 nop and any undefined opcode SHALL retire after T2 (T2 -> T0).
REQ-023 halt SHALL retire after T2 and enter HALTED: Run=0, all controls 0, step frozen until Clear.
REQ-024 Stop high at a T0 edge SHALL enter HALTED before any T0 controls take effect; Stop is ignored mid-instruction.
REQ-025 ALUsel SHALL be 0000 in every step not listed above; no two bus-drive selects SHALL be high in the same step.
REQ-026 An instruction retires on its final step; InstrCount SHALL increment by 1 per retirement and wrap 0xFFFFFFFF -> 0.

Reset
REQ-027 Clear high at an edge SHALL set step=T0, Run=1, InstrCount=0, leave HALTED; during any Clear-high cycle all control outputs SHALL be 0.
REQ-028 Clear SHALL override Stop and any in-flight instruction; the first cycle after Clear falls SHALL be T0.

Configuration
REQ-029 With INSTR_COUNT_EN defined, InstrCount SHALL behave per REQ-026; without it, InstrCount SHALL be tied to 0 and no counter register built.

Verification
REQ-030 Clear 1 cycle, IR=add (0x18000000) -> T0..T5 controls per REQ-013/015, ALUsel=0000 in T4, InstrCount=1 after T5.
REQ-031 IR=ld (0x00000000) -> 8 steps; Read high in T1 and T6; MDRout+Gra+Rin in T7; next cycle T0.
REQ-032 IR=br (0x90000000): CON=0 -> T6 all controls 0; CON=1 -> T6 Zlowout=1, PCin=1.
REQ-033 IR=jal (0x98000000) -> T3 PCout Grb Rin, T4 Gra Rout PCin, then T0; IR=0xF8000000 (undefined) -> T2 -> T0.
REQ-034 IR=halt (0xD8000000) -> Run=0 after T2, controls 0 for 10 cycles; Clear -> Run=1, T0.
REQ-035 Stop=1 at T0 and Clear=1 same edge -> Clear wins, Run=1; with INSTR_COUNT_EN, preload count 0xFFFFFFFF via 2^32 nops not required: force counter and check wrap to 0.
